// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit saturating counter, BTB entry
// layout and the counter update function.
package bp_pkg;

  localparam int TAG_W = 8;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } counter_t;

  localparam counter_t PHT_RESET = WNT;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } btb_entry_t;

  function automatic counter_t ctr_next(input counter_t c, input logic taken);
    counter_t n;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = PHT_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: array of 2-bit saturating counters with one
// combinational read port and one synchronous update port.
module bp_pht
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output counter_t            rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam int ENTRIES = 1 << IDX_BITS;

  counter_t ctr [ENTRIES];

  // Read returns the stored value; a same-cycle write is not forwarded.
  assign rd_ctr = ctr[rd_idx];

  // Counter array with saturating update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= PHT_RESET;
      end
    end else if (wr_en) begin
      ctr[wr_idx] <= ctr_next(ctr[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: bimodal PHT plus direct-mapped BTB looked up in F,
// prediction carried into D, trained from the resolved outcome in D.
// Define BP_GSHARE_EN to hash the PHT index with a global history register.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = TAG_W,
  parameter int GHR_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        update_en,
  input  logic        taken_d,
  input  logic [31:0] target_d,
  input  logic [31:0] pc_d,
  output logic        pred_f,
  output logic [31:0] pred_target_f,
  output logic        pred_d
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_LO  = IDX_BITS + 2;
  localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

  logic [IDX_BITS-1:0] idx_f;
  logic [IDX_BITS-1:0] pht_idx_f;
  logic [IDX_BITS-1:0] idx_d;
  logic [IDX_BITS-1:0] pht_idx_d;
  logic [TAG_BITS-1:0] tag_f;
  logic [TAG_BITS-1:0] tag_upd;
  logic                pred_r;
  logic                hit_f;
  counter_t            ctr_f;
  btb_entry_t          btb_rd;
  btb_entry_t          btb [ENTRIES];
  logic                unused_bits;

  assign idx_f   = pc_f[IDX_BITS+1:2];
  assign tag_f   = pc_f[TAG_HI:TAG_LO];
  assign tag_upd = pc_d[TAG_HI:TAG_LO];

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;

  assign pht_idx_f = idx_f ^ IDX_BITS'(ghr);

  // Non-speculative global history, advanced only by resolved branches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (update_en) begin
      ghr <= {ghr[GHR_BITS-2:0], taken_d};
    end
  end
`else
  localparam int unused_ghr_bits = GHR_BITS;
  assign pht_idx_f = idx_f;
`endif

  bp_pht #(
    .IDX_BITS(IDX_BITS)
  ) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pht_idx_f),
    .rd_ctr   (ctr_f),
    .wr_en    (update_en),
    .wr_idx   (pht_idx_d),
    .wr_taken (taken_d)
  );

  assign btb_rd        = btb[idx_f];
  assign hit_f         = btb_rd.valid & (btb_rd.tag == tag_f);
  assign pred_f        = hit_f & ctr_f[1];
  assign pred_target_f = btb_rd.target;
  assign pred_d        = pred_r;

  // BTB: a taken resolution overwrites whatever entry sits at that index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i] <= '0;
      end
    end else if (update_en && taken_d) begin
      btb[idx_d] <= '{valid: 1'b1, tag: tag_upd, target: target_d};
    end
  end

  // F->D prediction register; stall wins over flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_r    <= 1'b0;
      idx_d     <= '0;
      pht_idx_d <= '0;
    end else if (!stall_d) begin
      if (flush_d) begin
        pred_r    <= 1'b0;
        idx_d     <= '0;
        pht_idx_d <= '0;
      end else begin
        pred_r    <= pred_f;
        idx_d     <= idx_f;
        pht_idx_d <= pht_idx_f;
      end
    end
  end

  assign unused_bits = ^{pc_f[31:TAG_HI+1], pc_f[1:0],
                         pc_d[31:TAG_HI+1], pc_d[TAG_LO-1:0], ctr_f[0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a reference model predicts pred_f,
// pred_target_f and pred_d each cycle; directed sequences follow the test plan.
module tb_branch_predictor;

  localparam logic [31:0] P    = 32'h0040_0010;
  localparam logic [31:0] PT   = 32'h0040_0100;
  localparam logic [31:0] A2   = 32'h0040_1010;
  localparam logic [31:0] AT   = 32'h0040_0800;
  localparam logic [31:0] A3   = 32'h0041_0010;
  localparam logic [31:0] A3T  = 32'h0040_0400;
  localparam logic [31:0] Q    = 32'h0040_0020;
  localparam logic [31:0] QT   = 32'h0040_0200;
  localparam logic [31:0] FILL = 32'h0040_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_f, target_d, pc_d, pred_target_f;
  logic        stall_d, flush_d, update_en, taken_d, pred_f, pred_d;

  branch_predictor dut (
    .clk           (clk),
    .reset         (reset),
    .pc_f          (pc_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .update_en     (update_en),
    .taken_d       (taken_d),
    .target_d      (target_d),
    .pc_d          (pc_d),
    .pred_f        (pred_f),
    .pred_target_f (pred_target_f),
    .pred_d        (pred_d)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  bit [1:0]  m_pht [64];
  bit        m_v   [64];
  bit [7:0]  m_tag [64];
  bit [31:0] m_tgt [64];
  bit        m_pd;
  bit [5:0]  m_idx_d, m_pidx_d, m_ghr;
  bit        exp_q [$];
  bit        pd_q  [$];

  logic        obs_pf, obs_pd;
  logic [31:0] obs_tgt;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_pht[i] = 2'd1; m_v[i] = 1'b0; m_tag[i] = 8'd0; m_tgt[i] = 32'd0;
    end
    m_pd = 1'b0; m_idx_d = 6'd0; m_pidx_d = 6'd0; m_ghr = 6'd0;
    exp_q.delete();
    pd_q.delete();
    pd_q.push_back(1'b0);
  endtask

  task automatic step(input logic [31:0] pcf, input bit st, input bit fl,
                      input bit up, input bit tk, input logic [31:0] tgt,
                      input logic [31:0] pcd);
    bit [5:0]  i, pi;
    bit        e, ef;
    bit [31:0] et;
    @(negedge clk);
    pc_f = pcf; stall_d = st; flush_d = fl; update_en = up;
    taken_d = tk; target_d = tgt; pc_d = pcd;
    i  = pcf[7:2];
    pi = i;
`ifdef BP_GSHARE_EN
    pi = i ^ m_ghr;
`endif
    e  = m_v[i] && (m_tag[i] == pcf[15:8]) && m_pht[pi][1];
    et = m_tgt[i];
    exp_q.push_back(e);
    #1;
    obs_pf = pred_f; obs_pd = pred_d; obs_tgt = pred_target_f;
    ef = exp_q.pop_front();
    check("pred_f", pred_f, ef);
    if (ef) check("pred_target_f", pred_target_f, et);
    check("pred_d", pred_d, pd_q.pop_front());
    @(posedge clk);
    if (up) begin
      if (tk && m_pht[m_pidx_d] != 2'd3) m_pht[m_pidx_d]++;
      else if (!tk && m_pht[m_pidx_d] != 2'd0) m_pht[m_pidx_d]--;
      if (tk) begin
        m_v[m_idx_d] = 1'b1; m_tag[m_idx_d] = pcd[15:8]; m_tgt[m_idx_d] = tgt;
      end
      m_ghr = {m_ghr[4:0], tk};
    end
    if (!st) begin
      if (fl) begin
        m_pd = 1'b0; m_idx_d = 6'd0; m_pidx_d = 6'd0;
      end else begin
        m_pd = e; m_idx_d = i; m_pidx_d = pi;
      end
    end
    pd_q.push_back(m_pd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int mis;
    bit t;
    pc_f = 32'd0; stall_d = 1'b0; flush_d = 1'b1; update_en = 1'b0;
    taken_d = 1'b0; target_d = 32'd0; pc_d = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Untrained after reset
    step(P, 0, 0, 0, 0, 0, 0);
    check("reset_pf", obs_pf, 1'b0);
    step(P, 0, 0, 0, 0, 0, 0);
    check("reset_pd", obs_pd, 1'b0);

    // Train taken twice, then three not-taken
    step(P, 0, 0, 1, 1, PT, P);
    step(P, 0, 0, 1, 1, PT, P);
`ifndef BP_GSHARE_EN
    check("train_pf", obs_pf, 1'b1);
    check("train_tgt", obs_tgt, PT);
`endif
    repeat (3) step(P, 0, 0, 1, 0, PT, P);
    step(P, 0, 0, 0, 0, 0, 0);
`ifndef BP_GSHARE_EN
    check("nt3_pf", obs_pf, 1'b0);
`endif

    // Saturation at both ends
    repeat (5) step(P, 0, 0, 1, 1, PT, P);
    step(P, 0, 0, 1, 0, PT, P);
    step(P, 0, 0, 0, 0, 0, 0);
`ifndef BP_GSHARE_EN
    check("sat_hi_pf", obs_pf, 1'b1);
`endif
    repeat (5) step(P, 0, 0, 1, 0, PT, P);
    step(P, 0, 0, 1, 1, PT, P);
    step(P, 0, 0, 0, 0, 0, 0);
`ifndef BP_GSHARE_EN
    check("sat_lo_pf", obs_pf, 1'b0);
`endif

    // Stall beats flush; flush alone clears pred_d
    step(P, 0, 0, 1, 1, PT, P);
    step(P, 0, 0, 0, 0, 0, 0);
    step(P, 1, 1, 0, 0, 0, 0);
`ifndef BP_GSHARE_EN
    check("pre_stall_pd", obs_pd, 1'b1);
`endif
    step(P, 0, 1, 0, 0, 0, 0);
`ifndef BP_GSHARE_EN
    check("stall_hold_pd", obs_pd, 1'b1);
`endif
    step(P, 0, 0, 0, 0, 0, 0);
    check("flush_pd", obs_pd, 1'b0);

    // Same-cycle update and lookup: old counter visible, new one next cycle
    step(P, 0, 0, 1, 0, PT, P);
    step(P, 0, 0, 1, 1, PT, P);
`ifndef BP_GSHARE_EN
    check("same_old_pf", obs_pf, 1'b0);
`endif
    step(P, 0, 0, 0, 0, 0, 0);
`ifndef BP_GSHARE_EN
    check("same_new_pf", obs_pf, 1'b1);
`endif

    // Aliasing: differing tag evicts; 0x0041_0010 shares the tag of P
    step(P, 0, 0, 1, 1, AT, A2);
    step(P, 0, 0, 0, 0, 0, 0);
    check("alias_pf", obs_pf, 1'b0);
    step(A2, 0, 0, 0, 0, 0, 0);
`ifndef BP_GSHARE_EN
    check("alias_hit_pf", obs_pf, 1'b1);
    check("alias_tgt", obs_tgt, AT);
`endif
    step(P, 0, 0, 1, 1, A3T, A3);
    step(P, 0, 0, 0, 0, 0, 0);
`ifndef BP_GSHARE_EN
    check("alias_same_tag_pf", obs_pf, 1'b1);
    check("alias_same_tag_tgt", obs_tgt, A3T);
`endif

    // Alternating T/N branch, one fetch then one resolution per iteration
    mis = 0;
    for (int k = 0; k < 20; k++) begin
      t = (k % 2 == 0);
      step(Q, 0, 0, 0, 0, 0, 0);
      step(FILL, 0, 0, 1, t, QT, Q);
      if (obs_pd !== t) mis++;
`ifdef BP_GSHARE_EN
      if (k >= 12) check("gshare_pd", obs_pd, t);
`endif
    end
`ifndef BP_GSHARE_EN
    check("bimodal_mispred_ge_half", (mis * 2 >= 20), 1'b1);
`endif

    // Train, then reset mid-stream with update_en held high
    step(P, 0, 0, 0, 0, 0, 0);
    repeat (10) step(P, 0, 0, 1, 1, PT, P);
    step(P, 0, 0, 0, 0, 0, 0);
    check("prerst_pf", obs_pf, 1'b1);
    @(negedge clk);
    reset = 1'b1; update_en = 1'b1; taken_d = 1'b1; pc_d = P; target_d = PT;
    flush_d = 1'b1; stall_d = 1'b0; pc_f = P;
    #1;
    check("rst_async_pf", pred_f, 1'b0);
    check("rst_async_pd", pred_d, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; update_en = 1'b0; taken_d = 1'b0;
    step(P, 0, 0, 0, 0, 0, 0);
    check("postrst_pf", obs_pf, 1'b0);
    step(P, 0, 0, 1, 1, PT, P);
    step(P, 0, 0, 0, 0, 0, 0);
    step(P, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
